// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and the
// default stability window length.
package input_debouncer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam int DEF_STABLE_CYCLES = 8;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops reset to RST_VAL so the synchronized level is well defined
// while reset is asserted. Reusable by any input stage.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_p0  <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta_p0  <= async_in;
      sync_out <= meta_p0;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: accepts a new level on d only after STABLE_CYCLES
// consecutive identical samples that differ from the current d, and
// marks each accepted change with a one-cycle rise or fall pulse.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-FF synchronizer in front of
// the FSM so that in may be asynchronous to clk (adds two edges of latency).
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   CNT_W         = 4,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic d,
  output logic rise,
  output logic fall
);

  // Reject parameter sets where the window is too short or the counter
  // cannot represent STABLE_CYCLES-1.
  if (STABLE_CYCLES < 2 || (2 ** CNT_W) < STABLE_CYCLES) begin : g_param_err
    $error("input_debouncer: STABLE_CYCLES=%0d illegal for CNT_W=%0d",
           STABLE_CYCLES, CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             d_nxt;
  logic             accept;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff #(
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (in),
    .sync_out (s)
  );
`else
  assign s = in;
`endif

  // State, stability counter and accepted level registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      d     <= RST_VAL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      d     <= d_nxt;
    end
  end

  // Next-state logic: count consecutive samples that differ from d; any
  // sample equal to d abandons the count, so a window must restart cleanly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s != d) begin
          state_nxt = ST_CHECK;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (s == d) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          d_nxt     = s;
          accept    = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Edge pulses are registered alongside d so they line up with its change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & d_nxt;
      fall <= accept & ~d_nxt;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer with STABLE_CYCLES=4. Works with and
// without DEBOUNCE_SYNC_EN; the reference model accepts a new level when the
// last STABLE_CYCLES samples all differ from the current level.
module tb_input_debouncer;

  localparam int SC = 4;
  localparam int CW = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = SC + 2;
`else
  localparam int LAT = SC;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic in;
  logic d, rise, fall;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic m_d, m_rise, m_fall;
  logic m_sy1, m_sy2;
  logic hist[$];

  input_debouncer #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW),
    .RST_VAL       (1'b0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .d    (d),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_d    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_sy1  = 1'b0;
    m_sy2  = 1'b0;
  endtask

  // Advance one clock edge, update the model, settle 1 time unit past the edge.
  task automatic step();
    logic samp;
    bit   all_diff;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
`ifdef DEBOUNCE_SYNC_EN
      samp  = m_sy2;
      m_sy2 = m_sy1;
      m_sy1 = in;
`else
      samp = in;
`endif
      hist.push_back(samp);
      if (hist.size() > SC) void'(hist.pop_front());
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      all_diff = (hist.size() == SC);
      foreach (hist[i]) if (hist[i] == m_d) all_diff = 1'b0;
      if (all_diff) begin
        m_rise = ~m_d;
        m_fall = m_d;
        m_d    = ~m_d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in   = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({d, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_early: d/rise/fall=%b%b%b expected 000", d, rise, fall);
    end
    #5;
    n_cmp++;
    if ({d, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_after_edge: d/rise/fall=%b%b%b expected 000", d, rise, fall);
    end
    #4 in = 1'b0;
    #1 rstn = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      n_cmp++;
      if ({d, rise, fall} !== 3'b000 || {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL reset_release c=%0d: d/rise/fall=%b%b%b expected 000", c, d, rise, fall);
      end
    end
  endtask

  task automatic test_clean_rise();
    in = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      n_cmp++;
      if (d !== (c >= LAT) || rise !== (c == LAT) || fall !== 1'b0 ||
          {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL clean_rise c=%0d: d/rise/fall=%b%b%b expected %b%b0",
                 c, d, rise, fall, c >= LAT, c == LAT);
      end
    end
  endtask

  task automatic test_fall();
    in = 1'b0;
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      n_cmp++;
      if (d !== (c < LAT) || fall !== (c == LAT) || rise !== 1'b0 ||
          {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL fall c=%0d: d/rise/fall=%b%b%b expected %b0%b",
                 c, d, rise, fall, c < LAT, c == LAT);
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 1; c <= LAT + 6; c++) begin
      in = (c <= 3);
      step();
      n_cmp++;
      if ({d, rise, fall} !== 3'b000 || {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL glitch c=%0d: d/rise/fall=%b%b%b expected 000", c, d, rise, fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b111101;  // applied LSB first: 1,0,1,1,1,1
    for (int c = 1; c <= LAT + 5; c++) begin
      in = (c <= 6) ? pat[c-1] : 1'b1;
      step();
      n_cmp++;
      if (d !== (c >= LAT + 2) || rise !== (c == LAT + 2) || fall !== 1'b0 ||
          {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL bounce c=%0d: d/rise/fall=%b%b%b expected %b%b0",
                 c, d, rise, fall, c >= LAT + 2, c == LAT + 2);
      end
    end
    in = 1'b0;
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      n_cmp++;
      if ({d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL bounce_return c=%0d: d/rise/fall=%b%b%b expected %b%b%b",
                 c, d, rise, fall, m_d, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_mid_reset();
    in = 1'b1;
    repeat (2) step();
    rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({d, rise, fall} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_hold: d/rise/fall=%b%b%b expected 000", d, rise, fall);
    end
    #2 rstn = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      n_cmp++;
      if (d !== (c >= LAT) || rise !== (c == LAT) || fall !== 1'b0 ||
          {d, rise, fall} !== {m_d, m_rise, m_fall}) begin
        n_bad++;
        $display("FAIL mid_reset c=%0d: d/rise/fall=%b%b%b expected %b%b0",
                 c, d, rise, fall, c >= LAT, c == LAT);
      end
    end
  endtask

  task automatic test_random();
    int run;
    logic lvl;
    int c;
    c = 0;
    while (c < 600) begin
      lvl = 1'($urandom_range(0, 1));
      run = $urandom_range(1, SC + 3);
      for (int k = 0; k < run; k++) begin
        in = lvl;
        step();
        c++;
        n_cmp++;
        if ({d, rise, fall} !== {m_d, m_rise, m_fall} || (rise && fall)) begin
          n_bad++;
          $display("FAIL random c=%0d: d/rise/fall=%b%b%b expected %b%b%b",
                   c, d, rise, fall, m_d, m_rise, m_fall);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_fall();
    test_glitch();
    test_bounce();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
